// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the shared multiplier scheduler.
// FSM encoding and default geometry.
package mult_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int N_REQ_DEF = 4;

endpackage

// File: rtl/mult_share_sched_core.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
// Product register holds its value until the next start.
module shift_add_core
  import mult_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] p_q;
  logic [2*WIDTH-1:0] t_q;
  logic [WIDTH-1:0]   y_q;
  logic [CW-1:0]      cnt_q;

  // done marks the cycle whose closing edge adds the last bit
  assign done    = (cnt_q == CW'(1));
  assign product = p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q   <= '0;
      t_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
    end else if (start) begin
      p_q   <= '0;
      t_q   <= {{WIDTH{1'b0}}, x};
      y_q   <= y;
      cnt_q <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      if (y_q[0]) p_q <= p_q + t_q;
      t_q   <= t_q << 1;
      y_q   <= y_q >> 1;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin front end sharing one shift-add multiplier core.
// Arbiter, job FSM, owner id and response outputs.
module mult_share_sched
  import mult_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_x,
  input  logic [N_REQ*WIDTH-1:0] req_y,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]     rsp_result,
  output logic                   busy
);

  localparam logic [ID_W:0] NR = (ID_W + 1)'(N_REQ);

  state_t state_q;
  state_t state_d;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  win;
  logic [ID_W-1:0]  pick;
  logic [ID_W:0]    sum;
  logic [N_REQ-1:0] rot;
  logic             any;
  logic             accept;
  logic             rsp_hs;
  logic             core_done;
  logic [WIDTH-1:0] x_sel;
  logic [WIDTH-1:0] y_sel;

  // rotate so rr_ptr sits at bit 0, pick lowest, rotate back
  always_comb begin
    rot  = N_REQ'({req_valid, req_valid} >> rr_ptr);
    any  = 1'b0;
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any  = 1'b1;
        pick = ID_W'(i);
      end
    end
    sum = {1'b0, pick} + {1'b0, rr_ptr};
    win = (sum >= NR) ? ID_W'(sum - NR) : sum[ID_W-1:0];
  end

  assign accept    = (state_q == IDLE) && any && !rst;
  assign req_ready = accept ? (N_REQ'(1) << win) : '0;
  assign rsp_hs    = (state_q == DONE) && rsp_ready;
  assign x_sel     = req_x[win*WIDTH +: WIDTH];
  assign y_sel     = req_y[win*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (core_done) state_d = DONE;
      DONE:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) id_q <= win;
      if (rsp_hs) begin
        rr_ptr <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
      end
    end
  end

  shift_add_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .x      (x_sel),
    .y      (y_sel),
    .done   (core_done),
    .product(rsp_result)
  );

  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule
